knight_rider_monitor: RTL and testbench

//  Reads an 8-bit LED scanner bus (one lit LED bouncing end to end) and checks that it

---
 rtl/knight_rider_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_knight_rider_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_rider_monitor.sv
// rtl/knight_rider_monitor.sv - Knight-rider LED scan pattern monitor
//
// Purpose:
//   Watches a WIDTH-bit LED scanner bus. The bus should show one lit LED that
//   bounces between the two ends. The monitor locks onto a one-hot value, then
//   checks every later change against the legal scan pattern. It reports
//   position, direction, steps, bounces, illegal transitions and stalls.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   dataIn       in   WIDTH  LED bus under test (clk domain)
//   locked       out  1      tracking a valid scan
//   position     out  POSW   index of the lit bit
//   direction    out  1      1 = moving toward MSB, 0 = toward LSB
//   stepValid    out  1      one-cycle pulse per legal single-bit move
//   errorPulse   out  1      one-cycle pulse per illegal transition
//   stall        out  1      no change for TIMEOUT cycles while locked
//   bounceCount  out  CNTW   end reversals since reset (saturating)
//   errorCount   out  CNTW   illegal transitions since reset (saturating)

module knight_rider_monitor #(
  parameter int WIDTH   = 8,
  parameter int POSW    = 3,
  parameter int TIMEOUT = 50000000,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dataIn,
  output logic             locked,
  output logic [POSW-1:0]  position,
  output logic             direction,
  output logic             stepValid,
  output logic             errorPulse,
  output logic             stall,
  output logic [CNTW-1:0]  bounceCount,
  output logic [CNTW-1:0]  errorCount
);

  // Idle counter must be able to hold TIMEOUT itself (it saturates there).
  localparam int IDLEW = $clog2(TIMEOUT + 1);
  localparam logic [IDLEW-1:0] IDLE_MAX  = IDLEW'(TIMEOUT);
  localparam logic [IDLEW-1:0] IDLE_TRIP = IDLEW'(TIMEOUT - 1);
  localparam logic [IDLEW-1:0] IDLE_ONE  = IDLEW'(1);
  localparam logic [WIDTH-1:0] BUS_ONE   = WIDTH'(1);
  localparam logic [CNTW-1:0]  CNT_ONE   = CNTW'(1);

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [IDLEW-1:0]   idle_q, idle_d;
  logic               dir_known_q, dir_known_d;
  logic               locked_q, locked_d;
  logic [POSW-1:0]    position_q, position_d;
  logic               direction_q, direction_d;
  logic               step_q, step_d;
  logic               err_q, err_d;
  logic               stall_q, stall_d;
  logic [CNTW-1:0]    bounce_q, bounce_d;
  logic [CNTW-1:0]    errcnt_q, errcnt_d;

  // Decode of the incoming bus, shared by both states.
  logic               in_onehot;
  logic [POSW-1:0]    in_index;
  logic               up_match;
  logic               down_match;
  logic               new_dir;
  logic               prev_at_end;
  logic               reversal;
  logic               legal_step;

  always_comb begin
    in_onehot = (dataIn != '0) && ((dataIn & (dataIn - BUS_ONE)) == '0);
    in_index  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dataIn[i]) begin
        in_index = POSW'(i);
      end
    end
    // Requiring a one-hot target stops prev=MSB<<1 (all zeros) counting as a step.
    up_match    = in_onehot && (dataIn == (prev_q << 1));
    down_match  = in_onehot && (dataIn == (prev_q >> 1));
    new_dir     = up_match;
    prev_at_end = prev_q[0] | prev_q[WIDTH-1];
    reversal    = dir_known_q && (new_dir != direction_q);
    // A change of direction is only legal when the lit LED sat at an end.
    legal_step  = (up_match || down_match) && (!reversal || prev_at_end);
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    idle_d      = idle_q;
    dir_known_d = dir_known_q;
    locked_d    = locked_q;
    position_d  = position_q;
    direction_d = direction_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    stall_d     = stall_q;
    bounce_d    = bounce_q;
    errcnt_d    = errcnt_q;

    case (state_q)
      ST_SYNC: begin
        // Zero or multi-hot values simply keep us searching; they are not errors.
        if (in_onehot) begin
          state_d     = ST_LOCKED;
          locked_d    = 1'b1;
          position_d  = in_index;
          prev_d      = dataIn;
          dir_known_d = 1'b0;
          idle_d      = '0;
          stall_d     = 1'b0;
        end
      end

      ST_LOCKED: begin
        if (dataIn == prev_q) begin
          if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_ONE;
          end
          // Sticky once reached: the counter never falls back below the trip point.
          if (idle_q >= IDLE_TRIP) begin
            stall_d = 1'b1;
          end
        end else if (legal_step) begin
          step_d      = 1'b1;
          position_d  = in_index;
          direction_d = new_dir;
          prev_d      = dataIn;
          dir_known_d = 1'b1;
          idle_d      = '0;
          stall_d     = 1'b0;
          if (reversal && (bounce_q != '1)) begin
            bounce_d = bounce_q + CNT_ONE;
          end
        end else begin
          // Position and direction keep their last good values for debug.
          err_d       = 1'b1;
          locked_d    = 1'b0;
          stall_d     = 1'b0;
          dir_known_d = 1'b0;
          idle_d      = '0;
          state_d     = ST_SYNC;
          if (errcnt_q != '1) begin
            errcnt_d = errcnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      prev_q      <= '0;
      idle_q      <= '0;
      dir_known_q <= 1'b0;
      locked_q    <= 1'b0;
      position_q  <= '0;
      direction_q <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
      bounce_q    <= '0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      idle_q      <= idle_d;
      dir_known_q <= dir_known_d;
      locked_q    <= locked_d;
      position_q  <= position_d;
      direction_q <= direction_d;
      step_q      <= step_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      bounce_q    <= bounce_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign locked      = locked_q;
  assign position    = position_q;
  assign direction   = direction_q;
  assign stepValid   = step_q;
  assign errorPulse  = err_q;
  assign stall       = stall_q;
  assign bounceCount = bounce_q;
  assign errorCount  = errcnt_q;

endmodule

// File: tb/tb_knight_rider_monitor.sv
// tb/tb_knight_rider_monitor.sv - directed bench for knight_rider_monitor

module tb_knight_rider_monitor;

  logic        clk;
  logic        rst;
  logic [7:0]  dataIn;
  logic        locked;
  logic [2:0]  position;
  logic        direction;
  logic        stepValid;
  logic        errorPulse;
  logic        stall;
  logic [15:0] bounceCount;
  logic [15:0] errorCount;

  int passed;
  int total;

  knight_rider_monitor #(
    .WIDTH   (8),
    .POSW    (3),
    .TIMEOUT (16),
    .CNTW    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dataIn      (dataIn),
    .locked      (locked),
    .position    (position),
    .direction   (direction),
    .stepValid   (stepValid),
    .errorPulse  (errorPulse),
    .stall       (stall),
    .bounceCount (bounceCount),
    .errorCount  (errorCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    rst    = 1'b1;
    dataIn = 8'h00;
    tick();
    rst    = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    total++;
    if ({locked, position, direction, stepValid, errorPulse, stall} !== 8'h00 ||
        bounceCount !== 16'd0 || errorCount !== 16'd0)
      $display("FAIL reset_outputs: got l=%0b p=%0d d=%0b s=%0b e=%0b st=%0b b=%0d ec=%0d, want all 0",
               locked, position, direction, stepValid, errorPulse, stall, bounceCount, errorCount);
    else passed++;
  endtask

  task automatic test_lock;
    apply_reset();
    dataIn = 8'h01;
    tick();
    total++;
    if (locked !== 1'b1 || position !== 3'd0 || stepValid !== 1'b0)
      $display("FAIL lock_01: got l=%0b p=%0d s=%0b, want l=1 p=0 s=0", locked, position, stepValid);
    else passed++;
    tick();
    total++;
    if (locked !== 1'b1 || stepValid !== 1'b0 || errorPulse !== 1'b0)
      $display("FAIL lock_hold: got l=%0b s=%0b e=%0b, want l=1 s=0 e=0", locked, stepValid, errorPulse);
    else passed++;
  endtask

  task automatic test_sweep;
    logic [7:0] seq [14];
    int steps;
    int errs;
    int stalls;
    seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
            8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    steps  = 0;
    errs   = 0;
    stalls = 0;
    apply_reset();
    dataIn = 8'h01;
    for (int k = 0; k < 4; k++) tick();
    for (int i = 0; i < 14; i++) begin
      dataIn = seq[i];
      for (int k = 0; k < 4; k++) begin
        tick();
        if (stepValid)  steps++;
        if (errorPulse) errs++;
        if (stall)      stalls++;
      end
      if (i == 6) begin
        total++;
        if (position !== 3'd7 || direction !== 1'b1 || bounceCount !== 16'd0)
          $display("FAIL sweep_top: got p=%0d d=%0b b=%0d, want p=7 d=1 b=0", position, direction, bounceCount);
        else passed++;
      end
    end
    total++;
    if (steps !== 14)
      $display("FAIL sweep_steps: got %0d, want 14", steps);
    else passed++;
    total++;
    if (bounceCount !== 16'd1 || direction !== 1'b0 || position !== 3'd0)
      $display("FAIL sweep_end: got b=%0d d=%0b p=%0d, want b=1 d=0 p=0", bounceCount, direction, position);
    else passed++;
    total++;
    if (errorCount !== 16'd0 || errs !== 0 || stalls !== 0)
      $display("FAIL sweep_clean: got ec=%0d pulses=%0d stalls=%0d, want 0 0 0", errorCount, errs, stalls);
    else passed++;
  endtask

  task automatic test_jump_error;
    apply_reset();
    dataIn = 8'h04;
    tick();
    dataIn = 8'h10;
    tick();
    total++;
    if (errorPulse !== 1'b1 || errorCount !== 16'd1 || locked !== 1'b0 || stepValid !== 1'b0)
      $display("FAIL jump_err: got e=%0b ec=%0d l=%0b s=%0b, want e=1 ec=1 l=0 s=0",
               errorPulse, errorCount, locked, stepValid);
    else passed++;
    total++;
    if (position !== 3'd2)
      $display("FAIL jump_pos_hold: got %0d, want 2", position);
    else passed++;
    tick();
    total++;
    if (errorPulse !== 1'b0 || locked !== 1'b1 || position !== 3'd4 || errorCount !== 16'd1)
      $display("FAIL jump_relock: got e=%0b l=%0b p=%0d ec=%0d, want e=0 l=1 p=4 ec=1",
               errorPulse, locked, position, errorCount);
    else passed++;
  endtask

  task automatic test_mid_reversal;
    apply_reset();
    dataIn = 8'h04;
    tick();
    dataIn = 8'h08;
    tick();
    total++;
    if (stepValid !== 1'b1 || direction !== 1'b1 || position !== 3'd3)
      $display("FAIL midrev_step: got s=%0b d=%0b p=%0d, want s=1 d=1 p=3", stepValid, direction, position);
    else passed++;
    dataIn = 8'h04;
    tick();
    total++;
    if (errorPulse !== 1'b1 || stepValid !== 1'b0 || bounceCount !== 16'd0 ||
        errorCount !== 16'd1 || position !== 3'd3)
      $display("FAIL midrev_err: got e=%0b s=%0b b=%0d ec=%0d p=%0d, want e=1 s=0 b=0 ec=1 p=3",
               errorPulse, stepValid, bounceCount, errorCount, position);
    else passed++;
  endtask

  task automatic test_end_lock;
    apply_reset();
    dataIn = 8'h80;
    tick();
    dataIn = 8'h40;
    tick();
    total++;
    if (stepValid !== 1'b1 || bounceCount !== 16'd0 || direction !== 1'b0 || position !== 3'd6)
      $display("FAIL endlock: got s=%0b b=%0d d=%0b p=%0d, want s=1 b=0 d=0 p=6",
               stepValid, bounceCount, direction, position);
    else passed++;
  endtask

  task automatic test_stall;
    apply_reset();
    dataIn = 8'h20;
    tick();
    for (int k = 0; k < 15; k++) tick();
    total++;
    if (stall !== 1'b0)
      $display("FAIL stall_early: got %0b after 15 held cycles, want 0", stall);
    else passed++;
    tick();
    total++;
    if (stall !== 1'b1)
      $display("FAIL stall_set: got %0b after 16 held cycles, want 1", stall);
    else passed++;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (stall !== 1'b1 || locked !== 1'b1)
      $display("FAIL stall_sticky: got st=%0b l=%0b, want st=1 l=1", stall, locked);
    else passed++;
    dataIn = 8'h40;
    tick();
    total++;
    if (stall !== 1'b0 || stepValid !== 1'b1 || position !== 3'd6)
      $display("FAIL stall_clear: got st=%0b s=%0b p=%0d, want st=0 s=1 p=6", stall, stepValid, position);
    else passed++;
  endtask

  task automatic test_sync_noise_and_reset;
    int errs;
    int locks;
    errs  = 0;
    locks = 0;
    apply_reset();
    dataIn = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (errorPulse) errs++;
      if (locked) locks++;
    end
    dataIn = 8'h03;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (errorPulse) errs++;
      if (locked) locks++;
    end
    total++;
    if (errs !== 0 || locks !== 0 || errorCount !== 16'd0)
      $display("FAIL sync_noise: got errs=%0d locks=%0d ec=%0d, want 0 0 0", errs, locks, errorCount);
    else passed++;
    dataIn = 8'h40; tick();
    dataIn = 8'h80; tick();
    dataIn = 8'h40; tick();
    dataIn = 8'h10; tick();
    dataIn = 8'h20; tick();
    total++;
    if (bounceCount !== 16'd1 || errorCount !== 16'd1 || locked !== 1'b1 || position !== 3'd5)
      $display("FAIL pre_reset: got b=%0d ec=%0d l=%0b p=%0d, want b=1 ec=1 l=1 p=5",
               bounceCount, errorCount, locked, position);
    else passed++;
    rst = 1'b1;
    tick();
    total++;
    if ({locked, position, direction, stepValid, errorPulse, stall} !== 8'h00 ||
        bounceCount !== 16'd0 || errorCount !== 16'd0)
      $display("FAIL reset_midrun: got l=%0b p=%0d d=%0b s=%0b e=%0b st=%0b b=%0d ec=%0d, want all 0",
               locked, position, direction, stepValid, errorPulse, stall, bounceCount, errorCount);
    else passed++;
    rst = 1'b0;
    tick();
    total++;
    if (locked !== 1'b1 || position !== 3'd5 || stepValid !== 1'b0)
      $display("FAIL relock_after_reset: got l=%0b p=%0d s=%0b, want l=1 p=5 s=0", locked, position, stepValid);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    dataIn = 8'h00;
    test_reset();
    test_lock();
    test_sweep();
    test_jump_error();
    test_mid_reversal();
    test_end_lock();
    test_stall();
    test_sync_noise_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
